fma16_operand_stage: RTL and testbench
======================================

Name: fma16_operand_stage

Overview:
- Registered front-end stage of the fma16 datapath.
- Accepts one fma16 operation per beat (x, y, z plus op controls), applies the op controls to form effective operands, and splits them into sign/exponent/fraction fields.
- Delivers the fields, one cycle later, to the multiply/add core and the special-case logic downstream.
- 2-entry skid buffer with valid/ready on both sides: full throughput, registered in_ready.

Parameters:
- ONE_CONST, 16'h3C00, value substituted for y when mul=0 (+1.0).
- ZERO_CONST, 16'h0000, value substituted for z when add=0 (+0.0), before negz.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- x, y, z  in  16 each  raw half-precision operands
- mul, add, negp, negz  in  1 each  op controls
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_x, out_y, out_z  out  16 each  effective operands
- sign_x, sign_y, sign_z, sign_product  out  1 each  effective signs
- exponent_x, exponent_y, exponent_z  out  5 each  exponent fields
- fraction_x, fraction_y, fraction_z  out  10 each  fraction fields
- class_flags  out  12  {nan, inf, zero, subnormal} x {x, y, z}; see optional feature

Behaviour:
- Effective operands:
  - out_x = x.
  - out_y = mul ? y : ONE_CONST.
  - z' = add ? z : ZERO_CONST; out_z = {z'[15]^negz, z'[14:0]}.
- Field and sign rules:
  - Fields are taken from the effective operands.
  - sign_z = out_z[15].
  - sign_product = out_x[15] ^ out_y[15] ^ negp.
- Handshake:
  - accept = in_valid & in_ready; drain = out_valid & out_ready.
  - Beats drain in acceptance order; none are dropped or duplicated.
  - Latency: 1 cycle from accept to out_valid when the stage is empty.
  - Output data is held stable while out_valid & !out_ready.
- State machine (main register M, skid register S):
  - EMPTY: out_valid=0, in_ready=1. accept -> HOLD1 (beat into M).
  - HOLD1: out_valid=1, in_ready=1.
    - accept & drain -> HOLD1 (new beat into M).
    - accept & !drain -> HOLD2 (new beat into S).
    - !accept & drain -> EMPTY.
    - otherwise stay.
  - HOLD2: out_valid=1, in_ready=0. drain -> HOLD1 (S moves to M). in_valid is ignored.
- in_ready is a registered function of state: (state != HOLD2) & !reset-cycle.
- Reset:
  - Values: state=EMPTY, out_valid=0, in_ready=0 during the reset cycle and 1 the cycle after, all data/field/flag outputs 0.
  - Reset mid-operation discards M and S contents.
  - Reset dominates a simultaneous accept or drain.
- Simultaneous accept and drain in HOLD1 must not stall (full throughput).
- No arithmetic beyond the XORs; NaN payloads pass through unmodified.

Optional Feature:
- Macro: FMA16_CLASSIFY_EN.
- Defined:
  - class_flags is registered alongside the fields, computed from the effective operands.
  - Per operand: nan = exp==31 & frac!=0; inf = exp==31 & frac==0; zero = exp==0 & frac==0; subnormal = exp==0 & frac!=0.
  - Bit order [11:0] = {nan_x, nan_y, nan_z, inf_x, inf_y, inf_z, zero_x, zero_y, zero_z, sub_x, sub_y, sub_z}.
- Undefined: class_flags is tied to 12'b0 and no classification logic is present. The port always exists.

Decomposition:
- fma16_pkg holds:
  - typedef fma16_fields_t {sign, exponent[4:0], fraction[9:0]}.
  - typedef fma16_beat_t (effective x/y/z, signs, fields, flags).
  - Constants FP16_ONE=16'h3C00, FP16_QNAN=16'h7E00, FP16_POS_INF=16'h7C00, FP16_NEG_INF=16'hFC00, EXP_MAX=5'd31.
- One sub-module: fma16_field_split.
  - Combinational: operand -> fma16_fields_t plus class bits.
  - Instantiated three times ahead of the skid registers.

Test Plan:
- x=3C00, y=4000, z=3C00, mul=add=1, negp=negz=0, out_ready=1 -> next cycle: out_valid=1, exponent_y=16, fraction_y=0, sign_product=0, out_z=3C00.
- mul=0, y=7E00 -> out_y=3C00, exponent_y=15. add=0, negz=1, z=4500 -> out_z=8000, sign_z=1.
- x=BC00, y=3C00, negp=1 -> sign_product=0. Same operands with negp=0 -> sign_product=1.
- Backpressure: out_ready=0, send beats A, B, C back-to-back:
  - in_ready falls the cycle after B is accepted; C is held upstream.
  - Raise out_ready -> outputs A, B, C in order, one per cycle, with no gaps.
- Reset asserted while in HOLD2 -> next cycle out_valid=0, in_ready=0, outputs 0. Cycle after: in_ready=1, and no stale beat ever appears.
- FMA16_CLASSIFY_EN defined, x=7C01, y=0000, z=0001 -> class_flags=12'b100_000_010_001. Undefined -> class_flags=0.

Source files
------------

// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 datapath front end.
package fma16_pkg;

  localparam logic [15:0] FP16_ONE     = 16'h3C00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam logic [4:0]  EXP_MAX      = 5'd31;

  typedef struct packed {
    logic       sign;
    logic [4:0] exponent;
    logic [9:0] fraction;
  } fma16_fields_t;

  // One fully prepared operation as it sits in the main or skid register.
  typedef struct packed {
    logic [15:0]   x;
    logic [15:0]   y;
    logic [15:0]   z;
    fma16_fields_t fields_x;
    fma16_fields_t fields_y;
    fma16_fields_t fields_z;
    logic          sign_product;
    logic [11:0]   flags;
  } fma16_beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD1 = 2'd1,
    ST_HOLD2 = 2'd2
  } stage_state_t;

endpackage

// File: rtl/fma16_field_split.sv
// Splits one half-precision operand into sign/exponent/fraction and, when
// FMA16_CLASSIFY_EN is defined, its {nan, inf, zero, subnormal} class bits.
module fma16_field_split
  import fma16_pkg::*;
(
  input  logic [15:0]   operand,
  output fma16_fields_t fields,
  output logic [3:0]    class_bits
);

  assign fields.sign     = operand[15];
  assign fields.exponent = operand[14:10];
  assign fields.fraction = operand[9:0];

`ifdef FMA16_CLASSIFY_EN
  logic exp_max;
  logic exp_zero;
  logic frac_zero;

  assign exp_max    = (operand[14:10] == EXP_MAX);
  assign exp_zero   = (operand[14:10] == 5'd0);
  assign frac_zero  = (operand[9:0] == 10'd0);
  assign class_bits = {exp_max & ~frac_zero, exp_max & frac_zero,
                       exp_zero & frac_zero, exp_zero & ~frac_zero};
`else
  assign class_bits = 4'b0000;
`endif

endmodule

// File: rtl/fma16_operand_stage.sv
// Registered operand stage of the fma16 datapath with a 2-entry skid buffer.
// Optional classification outputs are enabled by defining FMA16_CLASSIFY_EN.
//
// state    | meaning
// ST_EMPTY | no beat held; out_valid=0, in_ready=1
// ST_HOLD1 | beat in main register M; out_valid=1, in_ready=1
// ST_HOLD2 | M presented, next beat parked in skid register S; in_ready=0
module fma16_operand_stage
  import fma16_pkg::*;
#(
  parameter logic [15:0] ONE_CONST  = FP16_ONE,
  parameter logic [15:0] ZERO_CONST = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic [15:0] out_z,
  output logic        sign_x,
  output logic        sign_y,
  output logic        sign_z,
  output logic        sign_product,
  output logic [4:0]  exponent_x,
  output logic [4:0]  exponent_y,
  output logic [4:0]  exponent_z,
  output logic [9:0]  fraction_x,
  output logic [9:0]  fraction_y,
  output logic [9:0]  fraction_z,
  output logic [11:0] class_flags
);

  logic [15:0]   eff_y;
  logic [15:0]   z_sel;
  logic [15:0]   eff_z;
  fma16_fields_t fx, fy, fz;
  logic [3:0]    cx, cy, cz;
  fma16_beat_t   beat_in;
  fma16_beat_t   main_q;
  fma16_beat_t   skid_q;
  stage_state_t  state, state_next;
  logic          in_ready_q;
  logic          accept, drain;
  logic          load_main, load_skid, move_skid;

  assign eff_y = mul ? y : ONE_CONST;
  assign z_sel = add ? z : ZERO_CONST;
  assign eff_z = {z_sel[15] ^ negz, z_sel[14:0]};

  fma16_field_split u_split_x (.operand(x),     .fields(fx), .class_bits(cx));
  fma16_field_split u_split_y (.operand(eff_y), .fields(fy), .class_bits(cy));
  fma16_field_split u_split_z (.operand(eff_z), .fields(fz), .class_bits(cz));

  always_comb begin
    beat_in              = '0;
    beat_in.x            = x;
    beat_in.y            = eff_y;
    beat_in.z            = eff_z;
    beat_in.fields_x     = fx;
    beat_in.fields_y     = fy;
    beat_in.fields_z     = fz;
    beat_in.sign_product = fx.sign ^ fy.sign ^ negp;
    beat_in.flags        = {cx[3], cy[3], cz[3], cx[2], cy[2], cz[2],
                            cx[1], cy[1], cz[1], cx[0], cy[0], cz[0]};
  end

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_HOLD1;
          load_main  = 1'b1;
        end
      end
      ST_HOLD1: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_next = ST_HOLD2;
          load_skid  = 1'b1;
        end else if (drain) begin
          state_next = ST_EMPTY;
        end
      end
      ST_HOLD2: begin
        if (drain) begin
          state_next = ST_HOLD1;
          load_main  = 1'b1;
          move_skid  = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // in_ready is registered from the next state so upstream never sees a comb path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != ST_HOLD2);
      if (load_main) main_q <= move_skid ? skid_q : beat_in;
      if (load_skid) skid_q <= beat_in;
    end
  end

  assign out_x        = main_q.x;
  assign out_y        = main_q.y;
  assign out_z        = main_q.z;
  assign sign_x       = main_q.fields_x.sign;
  assign sign_y       = main_q.fields_y.sign;
  assign sign_z       = main_q.fields_z.sign;
  assign sign_product = main_q.sign_product;
  assign exponent_x   = main_q.fields_x.exponent;
  assign exponent_y   = main_q.fields_y.exponent;
  assign exponent_z   = main_q.fields_z.exponent;
  assign fraction_x   = main_q.fields_x.fraction;
  assign fraction_y   = main_q.fields_y.fraction;
  assign fraction_z   = main_q.fields_z.fraction;
  assign class_flags  = main_q.flags;

endmodule

// File: tb/tb_fma16_operand_stage.sv
// Self-checking bench for fma16_operand_stage: directed steps plus random
// traffic scored against an in-order queue of arithmetically derived beats.
module tb_fma16_operand_stage;

  typedef struct packed {
    logic [15:0] ox, oy, oz;
    logic        sx, sy, sz, sp;
    logic [4:0]  ex, ey, ez;
    logic [9:0]  fx, fy, fz;
    logic [11:0] cf;
  } tb_beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0, y = '0, z = '0;
  logic        mul = 1'b0, add = 1'b0, negp = 1'b0, negz = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_x, out_y, out_z;
  logic        sign_x, sign_y, sign_z, sign_product;
  logic [4:0]  exponent_x, exponent_y, exponent_z;
  logic [9:0]  fraction_x, fraction_y, fraction_z;
  logic [11:0] class_flags;

  int total = 0;
  int bad = 0;
  tb_beat_t q[$];
  logic rst_prev = 1'b1;
  tb_beat_t snap;
  logic [15:0] specials[8] = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h0000,
                               16'h8000, 16'h0001, 16'h7C01, 16'h3C00};

  always #5 clk = ~clk;

  fma16_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .mul(mul), .add(add), .negp(negp), .negz(negz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .sign_x(sign_x), .sign_y(sign_y), .sign_z(sign_z), .sign_product(sign_product),
    .exponent_x(exponent_x), .exponent_y(exponent_y), .exponent_z(exponent_z),
    .fraction_x(fraction_x), .fraction_y(fraction_y), .fraction_z(fraction_z),
    .class_flags(class_flags)
  );

  function automatic logic [3:0] cls(logic [15:0] v);
    int e = int'(v) / 1024 % 32;
    int f = int'(v) % 1024;
    return {e == 31 && f != 0, e == 31 && f == 0, e == 0 && f == 0, e == 0 && f != 0};
  endfunction

  function automatic tb_beat_t model(logic [15:0] a, logic [15:0] b, logic [15:0] c,
                                     logic m_, logic ad, logic np, logic nz);
    tb_beat_t r;
    logic [15:0] zz;
`ifdef FMA16_CLASSIFY_EN
    logic [3:0] kx, ky, kz;
`endif
    r.ox = a;
    r.oy = m_ ? b : 16'h3C00;
    zz   = ad ? c : 16'h0000;
    r.oz = nz ? (zz ^ 16'h8000) : zz;
    r.sx = (r.ox >= 16'h8000);
    r.sy = (r.oy >= 16'h8000);
    r.sz = (r.oz >= 16'h8000);
    r.sp = r.sx ^ r.sy ^ np;
    r.ex = 5'(r.ox / 1024 % 32);
    r.ey = 5'(r.oy / 1024 % 32);
    r.ez = 5'(r.oz / 1024 % 32);
    r.fx = 10'(r.ox % 1024);
    r.fy = 10'(r.oy % 1024);
    r.fz = 10'(r.oz % 1024);
    r.cf = 12'b0;
`ifdef FMA16_CLASSIFY_EN
    kx = cls(r.ox);
    ky = cls(r.oy);
    kz = cls(r.oz);
    r.cf = {kx[3], ky[3], kz[3], kx[2], ky[2], kz[2],
            kx[1], ky[1], kz[1], kx[0], ky[0], kz[0]};
`endif
    return r;
  endfunction

  function automatic tb_beat_t obs_now();
    return {out_x, out_y, out_z, sign_x, sign_y, sign_z, sign_product,
            exponent_x, exponent_y, exponent_z, fraction_x, fraction_y, fraction_z,
            class_flags};
  endfunction

  task automatic check(string tag, logic [108:0] o, logic [108:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic drive(logic v, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                       logic m_, logic ad, logic np, logic nz);
    in_valid = v; x = a; y = b; z = c; mul = m_; add = ad; negp = np; negz = nz;
  endtask

  // One clock: score handshake at the negedge, then advance past the posedge.
  task automatic tick();
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = !rst_prev && (q.size() < 2);
    check("out_valid", 109'(out_valid), 109'(q.size() != 0));
    check("in_ready", 109'(in_ready), 109'(exp_rdy));
    if (!reset) begin
      if (out_valid && out_ready && q.size() > 0) check("beat", obs_now(), q.pop_front());
      if (in_valid && in_ready) q.push_back(model(x, y, z, mul, add, negp, negz));
    end
    @(posedge clk);
    rst_prev = reset;
    if (reset) q.delete();
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    check("reset_out_valid", 109'(out_valid), 109'(0));
    check("reset_in_ready", 109'(in_ready), 109'(0));
    check("reset_outputs", obs_now(), 109'(0));
    reset = 1'b0;
    tick();
    check("in_ready_after_reset", 109'(in_ready), 109'(1));

    // basic multiply-add beat
    out_ready = 1'b1;
    drive(1, 16'h3C00, 16'h4000, 16'h3C00, 1, 1, 0, 0);
    tick();
    in_valid = 1'b0;
    check("latency_valid", 109'(out_valid), 109'(1));
    check("exponent_y_2", 109'(exponent_y), 109'(5'd16));
    check("fraction_y_2", 109'(fraction_y), 109'(10'd0));
    check("sign_product_pos", 109'(sign_product), 109'(0));
    check("out_z_one", 109'(out_z), 109'(16'h3C00));
    tick();

    // mul=0 / add=0 substitution with negz
    drive(1, 16'h1234, 16'h7E00, 16'h4500, 0, 0, 0, 1);
    tick();
    in_valid = 1'b0;
    check("out_y_subst", 109'(out_y), 109'(16'h3C00));
    check("exponent_y_subst", 109'(exponent_y), 109'(5'd15));
    check("out_z_negzero", 109'(out_z), 109'(16'h8000));
    check("sign_z_neg", 109'(sign_z), 109'(1));
    tick();

    // negp handling, back to back at full throughput
    drive(1, 16'hBC00, 16'h3C00, 16'h0000, 1, 1, 1, 0);
    tick();
    check("sign_product_negp1", 109'(sign_product), 109'(0));
    drive(1, 16'hBC00, 16'h3C00, 16'h0000, 1, 1, 0, 0);
    tick();
    in_valid = 1'b0;
    check("sign_product_negp0", 109'(sign_product), 109'(1));
    tick();

    // classification
    drive(1, 16'h7C01, 16'h0000, 16'h0001, 1, 1, 0, 0);
    tick();
    in_valid = 1'b0;
`ifdef FMA16_CLASSIFY_EN
    check("class_flags", 109'(class_flags), 109'(12'b100_000_010_001));
`else
    check("class_flags", 109'(class_flags), 109'(12'b0));
`endif
    tick();

    // backpressure A, B, C
    out_ready = 1'b0;
    drive(1, 16'hA0A0, 16'h4100, 16'h0101, 1, 1, 0, 0);
    tick();
    drive(1, 16'hB0B0, 16'h4200, 16'h0202, 1, 1, 0, 0);
    tick();
    check("in_ready_full", 109'(in_ready), 109'(0));
    check("held_A", 109'(out_x), 109'(16'hA0A0));
    snap = obs_now();
    drive(1, 16'hC0C0, 16'h4300, 16'h0303, 1, 1, 0, 0);
    tick();
    check("hold_stable", obs_now(), snap);
    out_ready = 1'b1;
    for (int i = 0; i < 6 && in_valid; i++) begin
      tick();
      if (out_x == 16'hC0C0 || q.size() == 0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("abc_drained", 109'(q.size()), 109'(0));

    // reset while in HOLD2
    out_ready = 1'b0;
    drive(1, 16'h1111, 16'h2222, 16'h3333, 1, 1, 0, 0);
    tick();
    drive(1, 16'h4444, 16'h5555, 16'h6666, 1, 1, 1, 1);
    tick();
    check("hold2_before_reset", 109'(in_ready), 109'(0));
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    check("midreset_valid", 109'(out_valid), 109'(0));
    check("midreset_ready", 109'(in_ready), 109'(0));
    check("midreset_outputs", obs_now(), 109'(0));
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    check("postreset_ready", 109'(in_ready), 109'(1));
    repeat (3) tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 10) < 7,
            ($urandom % 4 == 0) ? specials[$urandom % 8] : 16'($urandom),
            ($urandom % 4 == 0) ? specials[$urandom % 8] : 16'($urandom),
            ($urandom % 4 == 0) ? specials[$urandom % 8] : 16'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      out_ready = ($urandom % 10) < 6;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("random_drained", 109'(q.size()), 109'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
